// File: rtl/regfile_dump.sv
// Debug read port for the 8 x 16-bit register file. On start it sweeps readnum
// across every register and streams each value out over valid/ready, then reports an XOR checksum.
module regfile_dump #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] rf_data,
    output logic [IDX_W-1:0]  readnum,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (idx == LAST_IDX) ? DONE : LOAD;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // readnum is updated one cycle ahead of LOAD, so the combinational regfile
    // output is already settled for the index being captured at the LOAD edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            readnum   <= '0;
            out_data  <= '0;
            out_index <= '0;
            acc       <= '0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        readnum <= '0;
                        acc     <= '0;
                    end
                end
                LOAD: begin
                    out_data  <= rf_data;
                    out_index <= idx;
                    acc       <= acc ^ rf_data;
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            checksum <= acc;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            readnum <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected words and checksums,
// a negedge monitor pops and compares them on each handshake and done pulse.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] rf_data;
    logic [2:0]  readnum;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [15:0] regs [0:7];

    logic [15:0] exp_data_q [$];
    logic [2:0]  exp_index_q [$];
    logic [15:0] exp_sum_q [$];

    int checks     = 0;
    int failures   = 0;
    int words_seen = 0;
    int dones_seen = 0;

    regfile_dump #(.NREGS(8), .DATA_W(16), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rf_data   (rf_data),
        .readnum   (readnum),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    assign rf_data = regs[readnum];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Queue one full dump's expected words and checksum, then pulse start for one edge.
    task automatic applyStimulus(input logic [15:0] word5, input logic [15:0] sum);
        logic [15:0] v;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      v = 16'h0042;
            else if (k == 5) v = word5;
            else             v = 16'(16'h1111 * k);
            exp_data_q.push_back(v);
            exp_index_q.push_back(3'(k));
        end
        exp_sum_q.push_back(sum);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_word(input int idx);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_index == 3'(idx)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wait_word", 32'(found), 1);
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (dones_seen >= target) break;
        end
        checkOutput("dump_finished", 32'(dones_seen), 32'(target));
        checkOutput("done_one_cycle", 32'(done), 0);
        checkOutput("idle_after_done", 32'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                checkOutput("word_pending", 32'(exp_data_q.size() > 0), 1);
                if (exp_data_q.size() > 0) begin
                    checkOutput("word_data", 32'(out_data), 32'(exp_data_q.pop_front()));
                    checkOutput("word_index", 32'(out_index), 32'(exp_index_q.pop_front()));
                end
                words_seen++;
            end
            if (done) begin
                checkOutput("done_pending", 32'(exp_sum_q.size() > 0), 1);
                if (exp_sum_q.size() > 0) begin
                    checkOutput("done_checksum", 32'(checksum), 32'(exp_sum_q.pop_front()));
                end
                checkOutput("done_words_left", 32'(exp_data_q.size()), 0);
                checkOutput("done_busy", 32'(busy), 0);
                dones_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        regs[0]   = 16'h0042;
        for (int k = 1; k < 8; k++) regs[k] = 16'(16'h1111 * k);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_readnum", 32'(readnum), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_index", 32'(out_index), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_checksum", 32'(checksum), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] full dump, no backpressure");
        applyStimulus(16'h5555, 16'h0042);
        checkOutput("lat_c1_valid", 32'(out_valid), 0);
        checkOutput("lat_c1_busy", 32'(busy), 1);
        checkOutput("lat_c1_readnum", 32'(readnum), 0);
        @(posedge clk); #1;
        checkOutput("lat_c2_valid", 32'(out_valid), 1);
        checkOutput("lat_c2_index", 32'(out_index), 0);
        checkOutput("busy_checksum_prev", 32'(checksum), 0);
        wait_done(1);
        checkOutput("checksum_hold", 32'(checksum), 32'h0042);

        $display("[TB] backpressure on word 3");
        applyStimulus(16'h5555, 16'h0042);
        wait_word(3);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(out_valid), 1);
            checkOutput("bp_data", 32'(out_data), 32'h3333);
            checkOutput("bp_index", 32'(out_index), 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(2);

        $display("[TB] start while busy");
        applyStimulus(16'h5555, 16'h0042);
        wait_word(2);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3);
        repeat (4) begin
            @(posedge clk); #1;
            checkOutput("no_restart_busy", 32'(busy), 0);
            checkOutput("no_restart_valid", 32'(out_valid), 0);
        end

        $display("[TB] write during dump, then back-to-back");
        applyStimulus(16'hBEEF, 16'hEBF8);
        wait_word(3);
        regs[5] = 16'hBEEF;
        wait_done(4);
        regs[5] = 16'h5555;
        applyStimulus(16'h5555, 16'h0042);
        checkOutput("b2b_prev_checksum", 32'(checksum), 32'hEBF8);
        wait_done(5);

        $display("[TB] reset mid-dump");
        base = words_seen;
        applyStimulus(16'h5555, 16'h0042);
        for (int c = 0; c < 40; c++) begin
            if (words_seen == base + 3) break;
            @(posedge clk); #1;
        end
        checkOutput("words_before_reset", 32'(words_seen - base), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_readnum", 32'(readnum), 0);
        checkOutput("mid_rst_checksum", 32'(checksum), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        exp_data_q.delete();
        exp_index_q.delete();
        exp_sum_q.delete();
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("post_rst_done", 32'(done), 0);
            checkOutput("post_rst_valid", 32'(out_valid), 0);
        end
        applyStimulus(16'h5555, 16'h0042);
        wait_done(6);

        checkOutput("queues_empty", 32'(exp_data_q.size() + exp_sum_q.size()), 0);
        checkOutput("total_words", 32'(words_seen), 32'(8 * 6 + 3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the 8 x 16-bit register file: on `start`, sweeps `readnum` 0..NREGS-1 and streams each register value out over a valid/ready handshake.
- Maintains a running XOR checksum of all words sent and reports it with a one-cycle `done` pulse.
- Sits beside the register file as a debug/verification read port: drives the regfile `readnum` input and consumes its combinational `data_out`.

Parameters:
- NREGS, 8, number of registers swept (2..8).
- DATA_W, 16, register data width.
- IDX_W, 3, width of `readnum` and `out_index`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- rf_data  input  DATA_W  regfile `data_out`, a combinational function of `readnum`.
- readnum  output  IDX_W  register index driven to the regfile.
- out_data  output  DATA_W  captured register value.
- out_index  output  IDX_W  index of `out_data`.
- out_valid  output  1  `out_data`/`out_index` are valid.
- out_ready  input  1  consumer accepts the word when high together with `out_valid`.
- busy  output  1  high in LOAD and SEND.
- done  output  1  one-cycle pulse after the last word is accepted.
- checksum  output  DATA_W  XOR of all words sent in the latest dump.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - State = IDLE, index counter = 0.
  - readnum, out_data, out_index, checksum = 0.
  - out_valid, busy, done = 0.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - start=1 at an edge → LOAD; index counter = 0; checksum accumulator cleared to 0.
  - start=0 → stay in IDLE.
- LOAD (1 cycle):
  - readnum = index counter.
  - At the edge: out_data <= rf_data; out_index <= index; checksum accumulator ^= rf_data; → SEND.
- SEND:
  - out_valid = 1.
  - out_data and out_index are held stable while out_ready = 0.
  - On an edge with out_ready = 1: if index == NREGS-1 → DONE, else index+1 → LOAD.
  - out_valid drops in the cycle after the handshake.
- DONE (1 cycle): done = 1, then → IDLE. Next-state logic for DONE does not look at start; it always returns to IDLE.
- checksum output:
  - Updates to the final accumulator value in the DONE cycle.
  - Holds that value until the next start or reset.
  - Not updated mid-dump: the output shows the previous result while busy.
- readnum:
  - Driven to the index counter in LOAD.
  - Holds its last value in all other states.
- Latency: start sampled at edge 0 → out_valid high from cycle 2.
  - With out_ready held at 1, each word takes 2 cycles.
  - done is high in cycle 2*NREGS+1.
- start while busy or in DONE: ignored. No restart and no queueing.
- Regfile writes during a dump are not blocked. Each word is the rf_data value sampled at its LOAD edge.
- Index never wraps. The counter stops at NREGS-1; no out-of-range readnum is ever issued.
- Reset asserted mid-dump → IDLE in the next cycle with all outputs at their reset values. The partial checksum is discarded.

Test Plan:
- Full dump, no backpressure:
  - Stimulus: preload R0=16'h0042 and Rk=16'h1111*k (k=1..7); pulse start; out_ready=1.
  - Required: 8 words in order, index 0..7, values 0042, 1111, 2222 … 7777.
  - Required: out_valid first high 2 cycles after the start edge; done a single cycle; checksum=16'h0042.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while word 3 is presented.
  - Required: out_valid, out_data=16'h3333 and out_index=3 stay constant; word 4 follows only after the handshake; checksum still 16'h0042.
- Start while busy:
  - Stimulus: assert start again mid-dump.
  - Required: exactly 8 words and one done pulse; busy=0 after done.
- Reset mid-dump:
  - Stimulus: assert reset after word 2 is accepted.
  - Required: next cycle out_valid=0, busy=0, readnum=0, checksum=0, no done pulse.
  - Required: a subsequent start produces a full dump from index 0.
- Write during dump:
  - Stimulus: write R5=16'hBEEF before R5 is loaded.
  - Required: word 5 = 16'hBEEF; checksum = 16'h0042 ^ 16'h5555 ^ 16'hBEEF.
- Back-to-back dumps:
  - Stimulus: start again immediately after done.
  - Required: identical output stream; checksum reflects the new dump only.
